// File: rtl/cpu_pkg.sv
// Shared types for the CPU flag datapath: condition codes, flag bit positions and flag word.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_AL = 4'h0,
    COND_EQ = 4'h1,
    COND_NE = 4'h2,
    COND_LT = 4'h3,
    COND_GE = 4'h4,
    COND_GT = 4'h5,
    COND_LE = 4'h6,
    COND_CS = 4'h7,
    COND_CC = 4'h8,
    COND_MI = 4'h9,
    COND_PL = 4'hA,
    COND_VS = 4'hB,
    COND_VC = 4'hC,
    COND_HI = 4'hD,
    COND_LS = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Flag word layout is {OF,CF,ZF,NF}.
  localparam int FLAG_OF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_NF = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cpu_cond_eval.sv
// Combinational branch-condition evaluator: (condition code, flags) -> taken.
module cpu_cond_eval
  import cpu_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   taken
);

  logic n_f, z_f, c_f, v_f, lt;

  assign n_f = flags[FLAG_NF];
  assign z_f = flags[FLAG_ZF];
  assign c_f = flags[FLAG_CF];
  assign v_f = flags[FLAG_OF];
  assign lt  = n_f ^ v_f;

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z_f;
      COND_NE: taken = !z_f;
      COND_LT: taken = lt;
      COND_GE: taken = !lt;
      COND_GT: taken = !z_f && !lt;
      COND_LE: taken = z_f || lt;
      COND_CS: taken = c_f;
      COND_CC: taken = !c_f;
      COND_MI: taken = n_f;
      COND_PL: taken = !n_f;
      COND_VS: taken = v_f;
      COND_VC: taken = !v_f;
      COND_HI: taken = c_f && !z_f;
      COND_LS: taken = !c_f || z_f;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_flag_unit.sv
// Architectural flag register with per-flag ALU updates, forwarded branch evaluation
// and a flag save stack for interrupt entry/return.
module cpu_flag_unit
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic       alu_of,
  input  logic       alu_cf,
  input  logic       alu_zf,
  input  logic       alu_nf,
  input  logic       alu_of_en,
  input  logic       alu_cf_en,
  input  logic       alu_zf_en,
  input  logic       alu_nf_en,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  output logic       br_ready,
  output logic       br_resp_valid,
  output logic       br_taken,
  input  logic       br_resp_ready,
  input  logic       flag_push,
  input  logic       flag_pop,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err,
  output logic [3:0] flags
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  flags_t          flags_q, flags_d;
  flags_t          stack_q [STACK_DEPTH];
  flags_t          stack_d [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            resp_valid_q, resp_valid_d;
  logic            taken_q, taken_d;
  logic            err_q, err_d;

  flags_t alu_vec, en_vec, pop_data;
  logic   push_ok, pop_ok, accept, cond_taken;

  assign alu_vec = {alu_of, alu_cf, alu_zf, alu_nf};
  assign en_vec  = {alu_of_en, alu_cf_en, alu_zf_en, alu_nf_en};

  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign push_ok     = flag_push && !flag_pop && !stack_full;
  assign pop_ok      = flag_pop && !flag_push && !stack_empty;

  // Handshake: a request is accepted on br_valid & br_ready; the response is held
  // (valid and taken stable) until br_resp_valid & br_resp_ready. A new request may be
  // accepted in the same cycle the pending response is consumed.
  assign br_ready = !resp_valid_q || br_resp_ready;
  assign accept   = br_valid && br_ready;

  // Evaluated on next-state flags so a same-cycle ALU update or pop is forwarded.
  cpu_cond_eval u_cond_eval (
    .cond  (cond_e'(br_cond)),
    .flags (flags_d),
    .taken (cond_taken)
  );

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i) == sp_q - SP_W'(1)) pop_data = stack_q[i];
    end

    flags_d = flags_q;
    if (pop_ok) flags_d = pop_data;
    else if (alu_valid) flags_d = (alu_vec & en_vec) | (flags_q & ~en_vec);

    stack_d = stack_q;
    sp_d    = sp_q;
    if (push_ok) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (SP_W'(i) == sp_q) stack_d[i] = flags_d;
      end
      sp_d = sp_q + SP_W'(1);
    end else if (pop_ok) begin
      sp_d = sp_q - SP_W'(1);
    end

    err_d = (flag_push && flag_pop) ||
            (flag_push && stack_full) ||
            (flag_pop && stack_empty);

    resp_valid_d = resp_valid_q;
    taken_d      = taken_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      taken_d      = cond_taken;
    end else if (br_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= '0;
      sp_q         <= '0;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      sp_q         <= sp_d;
      resp_valid_q <= resp_valid_d;
      taken_q      <= taken_d;
      err_q        <= err_d;
    end
  end

  // Stack contents are don't-care after reset; only sp defines what is live.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign flags         = flags_q;
  assign br_resp_valid = resp_valid_q;
  assign br_taken      = taken_q;
  assign stack_err     = err_q;

endmodule

// File: tb/tb_cpu_flag_unit.sv
// Self-checking bench for cpu_flag_unit: directed scenarios plus random traffic,
// checked against a queue-based flag/stack model and a branch response scoreboard.
module tb_cpu_flag_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_valid = 1'b0;
  logic       alu_of = 1'b0, alu_cf = 1'b0, alu_zf = 1'b0, alu_nf = 1'b0;
  logic       alu_of_en = 1'b0, alu_cf_en = 1'b0, alu_zf_en = 1'b0, alu_nf_en = 1'b0;
  logic       br_valid = 1'b0;
  logic [3:0] br_cond = 4'h0;
  logic       br_ready, br_resp_valid, br_taken;
  logic       br_resp_ready = 1'b0;
  logic       flag_push = 1'b0, flag_pop = 1'b0;
  logic       stack_full, stack_empty, stack_err;
  logic [3:0] flags;

  cpu_flag_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_of        (alu_of),
    .alu_cf        (alu_cf),
    .alu_zf        (alu_zf),
    .alu_nf        (alu_nf),
    .alu_of_en     (alu_of_en),
    .alu_cf_en     (alu_cf_en),
    .alu_zf_en     (alu_zf_en),
    .alu_nf_en     (alu_nf_en),
    .br_valid      (br_valid),
    .br_cond       (br_cond),
    .br_ready      (br_ready),
    .br_resp_valid (br_resp_valid),
    .br_taken      (br_taken),
    .br_resp_ready (br_resp_ready),
    .flag_push     (flag_push),
    .flag_pop      (flag_pop),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .stack_err     (stack_err),
    .flags         (flags)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Current state (after the most recent edge) and the state expected after the next edge.
  logic [3:0] m_flags, n_flags;
  logic [3:0] m_stack[$], n_stack[$];
  logic       m_rv, n_rv;
  logic       m_err, n_err;
  logic       exp_ready;
  logic [0:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // Condition rules written directly from the architectural table; f = {V,C,Z,N}.
  function automatic logic cond_ref(input logic [3:0] code, input logic [3:0] f);
    logic v, c, z, n;
    v = f[3]; c = f[2]; z = f[1]; n = f[0];
    case (code)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return n != v;
      4'h4: return n == v;
      4'h5: return !z && (n == v);
      4'h6: return z || (n != v);
      4'h7: return c;
      4'h8: return !c;
      4'h9: return n;
      4'hA: return !n;
      4'hB: return v;
      4'hC: return !v;
      4'hD: return c && !z;
      4'hE: return !c || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic av, input logic [3:0] alu, input logic [3:0] en,
                       input logic bv, input logic [3:0] cc, input logic rr,
                       input logic ps, input logic pp);
    logic       acc, push_ok, pop_ok;
    logic [3:0] f;
    @(posedge clk);
    m_flags = n_flags; m_stack = n_stack; m_rv = n_rv; m_err = n_err;
    #1;
    alu_valid = av;
    {alu_of, alu_cf, alu_zf, alu_nf} = alu;
    {alu_of_en, alu_cf_en, alu_zf_en, alu_nf_en} = en;
    br_valid = bv; br_cond = cc; br_resp_ready = rr;
    flag_push = ps; flag_pop = pp;

    exp_ready = !m_rv || rr;
    acc       = bv && exp_ready;
    push_ok   = ps && !pp && (m_stack.size() < DEPTH);
    pop_ok    = pp && !ps && (m_stack.size() > 0);

    f = m_flags;
    if (pop_ok) f = m_stack[$];
    else if (av) begin
      for (int i = 0; i < 4; i++) if (en[i]) f[i] = alu[i];
    end

    n_flags = f;
    n_stack = m_stack;
    if (pop_ok) void'(n_stack.pop_back());
    if (push_ok) n_stack.push_back(f);
    n_err = (ps && pp) || (ps && !pp && m_stack.size() == DEPTH) ||
            (pp && !ps && m_stack.size() == 0);
    if (acc) begin
      exp_q.push_back(cond_ref(cc, f));
      n_rv = 1'b1;
    end else if (rr) n_rv = 1'b0;
    else n_rv = m_rv;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, rr, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    alu_valid = 1'b0; br_valid = 1'b0; br_resp_ready = 1'b0;
    flag_push = 1'b0; flag_pop = 1'b0;
    m_flags = '0; n_flags = '0;
    m_stack.delete(); n_stack.delete();
    m_rv = 1'b0; n_rv = 1'b0; m_err = 1'b0; n_err = 1'b0;
    exp_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("flags", 32'(flags), 32'(m_flags));
      chk("resp_valid", 32'(br_resp_valid), 32'(m_rv));
      chk("br_ready", 32'(br_ready), 32'(exp_ready));
      chk("stack_err", 32'(stack_err), 32'(m_err));
      chk("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      chk("stack_full", 32'(stack_full), 32'(m_stack.size() == DEPTH));
      if (br_resp_valid) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 32'(1), 32'(0));
        else begin
          chk("br_taken", 32'(br_taken), 32'(exp_q[0]));
          if (br_resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_flags = '0; n_flags = '0; m_rv = 1'b0; n_rv = 1'b0;
    m_err = 1'b0; n_err = 1'b0; exp_ready = 1'b1;
    mon_en = 1'b1;
    do_reset();

    // T1: reset while a response is stalled
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    do_reset();

    // T2: partial enables
    drive(1'b1, 4'b1111, 4'b0011, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    do_reset();

    // T3: forwarding of a same-cycle ZF update into EQ, then NE
    drive(1'b1, 4'b0010, 4'b0010, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // T4: backpressure with flags changing underneath the held response
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0000, 4'b0010, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1000, 4'b1000, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    do_reset();

    // T5: push, overwrite, pop restores; pop discards same-cycle ALU update
    drive(1'b1, 4'b1010, 4'b1111, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'b0101, 4'b1111, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'b0101, 4'b1111, 1'b1, 4'hB, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // T6: overflow, underflow, simultaneous push+pop
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 4'(i + 3), 4'b1111, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'b0110, 4'b1111, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'b1001, 4'b0101, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    repeat (4) idle(1'b1);
    @(negedge clk);
    @(posedge clk);
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
